fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined CPU: holds the program counter, drives the instruction memory's address and read enable, and captures the returned word into the IF/ID pipeline register for decode. Sits directly upstream of the instruction memory, whose output is valid in the same cycle the address is presented (latched on clock low), and directly upstream of decode. Handles hazard-unit stalls, branch redirects and flushes, and halt detection.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/ifid_reg.sv | 29 ++
 rtl/fetch_stage.sv | 59 +++++
 tb/tb_fetch_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and word/address types shared by the fetch and decode stages.
package cpu_pkg;
    typedef logic [15:0] word_t;
    typedef logic [15:0] addr_t;
    localparam word_t NOP_INSTR = 16'h0000;
    localparam addr_t RESET_PC = 16'h0000;
    localparam logic [3:0] OPC_HLT = 4'hF;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    function automatic logic [3:0] opcode(input word_t w);
        return w[OPC_MSB:OPC_LSB];
    endfunction
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register; flush loads a bubble and beats hold.
module ifid_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  flush,
    input  word_t instr,
    input  addr_t pc_inc,
    output word_t ifid_instr,
    output addr_t ifid_pc_inc,
    output logic  ifid_valid
);
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr  <= NOP_INSTR;
            ifid_pc_inc <= 16'h0000;
            ifid_valid  <= 1'b0;
        end else if (flush) begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (!hold) begin
            ifid_instr  <= instr;
            ifid_pc_inc <= pc_inc;
            ifid_valid  <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC selection and IF/ID capture for the 16-bit pipeline.
// Define FETCH_HALT_EN to stop fetching after an HLT word is captured.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  branch_taken,
    input  addr_t branch_target,
    input  word_t im_instr,
    output addr_t im_addr,
    output logic  im_rd_en,
    output word_t ifid_instr,
    output addr_t ifid_pc_inc,
    output logic  ifid_valid,
    output logic  halted
);
    addr_t pc;
    addr_t pc_inc;
    logic  hlt_hit;
    assign pc_inc   = pc + 16'd1;
    assign im_addr  = pc;
    assign im_rd_en = ~rst & ~stall & ~halted;
`ifdef FETCH_HALT_EN
    logic halt_q;
    // Only a normal fetch cycle may latch a halt; branch and stall take precedence.
    assign hlt_hit = (opcode(im_instr) == OPC_HLT) & ~branch_taken & ~stall & ~halt_q;
    assign halted  = halt_q;
    always_ff @(posedge clk) begin
        if (rst || branch_taken)
            halt_q <= 1'b0;
        else if (hlt_hit)
            halt_q <= 1'b1;
    end
`else
    assign hlt_hit = 1'b0;
    assign halted  = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (branch_taken)
            pc <= branch_target;
        else if (!stall && !halted && !hlt_hit)
            pc <= pc_inc;
    end
    ifid_reg u_ifid (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall),
        .flush      (branch_taken | (halted & ~stall)),
        .instr      (im_instr),
        .pc_inc     (pc_inc),
        .ifid_instr (ifid_instr),
        .ifid_pc_inc(ifid_pc_inc),
        .ifid_valid (ifid_valid)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed values.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] im_instr;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_inc;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] hlt_addr = 16'h0007;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef FETCH_HALT_EN
    localparam bit HALT_ON = 1'b1;
`else
    localparam bit HALT_ON = 1'b0;
`endif

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .im_instr     (im_instr),
        .im_addr      (im_addr),
        .im_rd_en     (im_rd_en),
        .ifid_instr   (ifid_instr),
        .ifid_pc_inc  (ifid_pc_inc),
        .ifid_valid   (ifid_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: HLT at hlt_addr, otherwise 0xA plus the low 12 address bits.
    assign im_instr = (im_addr == hlt_addr) ? 16'hF000 : {4'hA, im_addr[11:0]};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic [15:0] inc, input logic v);
        chk({tag, ".instr"}, ifid_instr, ins);
        chk({tag, ".pc_inc"}, ifid_pc_inc, inc);
        chk({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, v});
    endtask

    initial begin
        step();
        step();
        chk("rst.rd_en", {15'd0, im_rd_en}, 16'd0);
        chk("rst.addr", im_addr, 16'h0000);
        chk("rst.halted", {15'd0, halted}, 16'd0);
        chk_ifid("rst", 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;
        #1;
        chk("run.rd_en", {15'd0, im_rd_en}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_ifid("run", 16'hA000 + 16'(i), 16'(i + 1), 1'b1);
        end
        chk("run.addr4", im_addr, 16'h0004);
        step();
        chk("run.addr5", im_addr, 16'h0005);

        stall = 1'b1;
        #1;
        chk("stall.rd_en", {15'd0, im_rd_en}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.addr", im_addr, 16'h0005);
            chk_ifid("stall", 16'hA004, 16'h0005, 1'b1);
        end
        stall = 1'b0;
        step();
        chk_ifid("resume", 16'hA005, 16'h0006, 1'b1);
        chk("resume.addr", im_addr, 16'h0006);

        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 16'h0040;
        step();
        chk("br.addr", im_addr, 16'h0040);
        chk_ifid("br", 16'h0000, 16'h0006, 1'b0);
        stall = 1'b0;
        branch_taken = 1'b0;
        step();
        chk_ifid("br_tgt", 16'hA040, 16'h0041, 1'b1);

        branch_taken = 1'b1;
        branch_target = 16'h0005;
        step();
        branch_taken = 1'b0;
        step();
        step();
        chk("hlt.addr7", im_addr, 16'h0007);
        step();
        chk_ifid("hlt", 16'hF000, 16'h0008, 1'b1);
        chk("hlt.halted", {15'd0, halted}, {15'd0, HALT_ON});
        chk("hlt.addr", im_addr, HALT_ON ? 16'h0007 : 16'h0008);
        chk("hlt.rd_en", {15'd0, im_rd_en}, {15'd0, ~HALT_ON});
        step();
        if (HALT_ON) chk_ifid("hlt_bub", 16'h0000, 16'h0008, 1'b0);
        else chk_ifid("hlt_bub", 16'hA008, 16'h0009, 1'b1);
        chk("hlt_bub.addr", im_addr, HALT_ON ? 16'h0007 : 16'h0009);
        branch_taken = 1'b1;
        branch_target = 16'h0010;
        step();
        branch_taken = 1'b0;
        chk("unhlt.halted", {15'd0, halted}, 16'd0);
        chk("unhlt.addr", im_addr, 16'h0010);
        chk("unhlt.valid", {15'd0, ifid_valid}, 16'd0);
        step();
        chk_ifid("unhlt", 16'hA010, 16'h0011, 1'b1);

        branch_taken = 1'b1;
        branch_target = 16'hFFFF;
        step();
        branch_taken = 1'b0;
        chk("wrap.addr", im_addr, 16'hFFFF);
        step();
        chk_ifid("wrap", 16'hAFFF, 16'h0000, 1'b1);
        chk("wrap.next", im_addr, 16'h0000);

        hlt_addr = 16'h0022;
        branch_taken = 1'b1;
        branch_target = 16'h0020;
        step();
        branch_taken = 1'b0;
        step();
        step();
        step();
        chk("mid.halted", {15'd0, halted}, {15'd0, HALT_ON});
        chk("mid.addr", im_addr, HALT_ON ? 16'h0022 : 16'h0023);
        rst = 1'b1;
        step();
        chk("mid_rst.addr", im_addr, 16'h0000);
        chk("mid_rst.halted", {15'd0, halted}, 16'd0);
        chk("mid_rst.rd_en", {15'd0, im_rd_en}, 16'd0);
        chk_ifid("mid_rst", 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;
        step();
        chk_ifid("post_rst", 16'hA000, 16'h0001, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
